short_multi: RTL and testbench
==============================

# short_multi

Parametrised, multi-channel successor to the single-channel ready/busy request model. Tracks `NCH` independent channels, each with a ready/busy status FSM. A round-robin arbiter admits at most one requesting ready channel per cycle. An admitted channel stays busy for a programmable number of cycles or until it is released early. It sits in front of a shared resource, as the admission/occupancy tracker that verification properties (no starvation, one grant per cycle, bounded busy time) are written against.

## Interface
Parameters:
- `NCH`, default 4: number of channels, 2..16.
- `BUSY_W`, default 3: width of the busy-length counter.

Ports:
- `clk`  in  1: single clock; all state updates on posedge.
- `reset_n`  in  1: reset is synchronous and active-low.
- `request`  in  NCH: per-channel request, level, sampled at posedge.
- `release`  in  NCH: per-channel early release, sampled at posedge.
- `busy_len`  in  BUSY_W: busy duration loaded into the channel granted this cycle.
- `grant`  out  NCH: registered one-hot admission pulse, one cycle wide.
- `busy`  out  NCH: per-channel status, 1 = busy, 0 = ready.
- `nbusy`  out  $clog2(NCH+1): count of busy channels.
- `all_busy`  out  1: all channels busy.

## Operation
- Per-channel states are `ready` and `busy`; each channel has a `BUSY_W`-bit down-counter `cnt`.
- A channel is eligible when it is in `ready` and `request[i]` = 1. Requests from busy channels are ignored, not queued.
- Arbiter:
  - Searches for an eligible channel from pointer `ptr` upward, modulo NCH.
  - The first hit `w` is granted.
  - On a grant, `ptr` <= (w+1) mod NCH. With no grant, `ptr` holds.
- On grant of `w`:
  - state[w] <= `busy`.
  - cnt[w] <= `busy_len`, except that `busy_len` = 0 loads 1.
  - grant <= onehot(w).
  - Only one grant per cycle; other eligible channels wait.
- In `busy` each cycle, in priority order:
  - If release[i] = 1: go to `ready` and set cnt <= 0.
  - Else if cnt = 1: go to `ready` and set cnt <= 0.
  - Else cnt <= cnt-1.
- `release` on a ready channel is ignored.
- A channel leaving `busy` at an edge is not eligible at that same edge. It is eligible from the next edge.
- `nbusy` and `all_busy` are registered, computed from next-state, so they are consistent with `busy` in the same cycle.

## Timing
- Reset (reset_n = 0 at posedge): all channels `ready`, cnt = 0, ptr = 0, grant = 0, busy = 0, nbusy = 0, all_busy = 0. This applies mid-operation too: any busy channel is dropped and pending grants are lost.
- Grant latency: request sampled at edge k gives grant and busy = 1 visible after edge k, during cycle k+1.
- Busy length L (after the 0->1 mapping): busy is high for exactly L cycles, then the channel is ready.
  - Earliest re-grant of the same channel: edge k+L+1.
- Release sampled at edge j while busy: busy = 0 after edge j, overriding the counter. Expiry and release in the same cycle still give ready.
- `busy_len` is sampled only at the edge where the grant occurs.
- `grant` never has more than one bit set, and is 0 in any cycle after reset.

## Structure
- Package `short_pkg`:
  - `typedef enum {ready, busy} status`.
  - The default `NCH`/`BUSY_W` constants.
  - A function `min1(len)` implementing the 0->1 mapping.
- Sub-module `short_chan`: one channel's status FSM and down-counter. Inputs: clk, reset_n, take, len, release. Outputs: status, free.
- Top `short_multi` instantiates `NCH` `short_chan` instances, plus the round-robin arbiter, the pointer and the popcount.

## Test plan
- Reset: drive requests during reset_n = 0. Required: grant = 0, busy = 0 and nbusy = 0 throughout, and ptr = 0 after the deassertion edge.
- Single request: NCH = 4, busy_len = 3, request = 0001 held. Required: grant = 0001 in one cycle, busy[0] high for exactly 3 cycles, re-grant on the 4th edge after.
- Round-robin: request = 1111 held, busy_len = 7. Required: grant sequence 0001, 0010, 0100, 1000 on consecutive cycles, then all_busy = 1 and nbusy = 4.
- Fairness after wrap: ptr = 2, request = 0011. Required: channel 0 is granted first, then channel 1.
- Early release and simultaneity: channel 1 busy with cnt = 1, release[1] = 1. Required: ready after one edge, with no double transition; `release` on a ready channel causes no change.
- Zero length and mid-operation reset: busy_len = 0 gives a 1-cycle busy. reset_n = 0 while 3 channels are busy gives all ready next cycle and grant = 0.

Source files
------------

// File: rtl/short_pkg.sv
// Shared types, default sizing and helpers for the multi-channel
// ready/busy admission tracker.
package short_pkg;

  localparam int NCH_DEF    = 4;
  localparam int BUSY_W_DEF = 3;

  typedef enum logic {
    ready = 1'b0,
    busy  = 1'b1
  } status_e;

  // A zero busy length still occupies the channel for one cycle.
  function automatic int unsigned min1(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/short_chan.sv
// One channel: ready/busy status FSM with a busy-length down-counter.
// `release` is a reserved word, so the early-release input is early_release.
module short_chan
  import short_pkg::*;
#(
  parameter int BUSY_W = BUSY_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take,
  input  logic [BUSY_W-1:0] len,
  input  logic              early_release,
  output status_e           status,
  output logic              free,
  output logic              busy_nxt
);

  logic [BUSY_W-1:0] cnt;
  logic [BUSY_W-1:0] cnt_nxt;
  status_e           status_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what keeps latches from being inferred.
  always_comb begin
    status_nxt = status;
    cnt_nxt    = cnt;
    if (status == busy) begin
      // Release wins over the counter; expiry and release together still end busy.
      if (early_release || cnt == BUSY_W'(1)) begin
        status_nxt = ready;
        cnt_nxt    = '0;
      end else begin
        cnt_nxt = cnt - BUSY_W'(1);
      end
    end else if (take) begin
      status_nxt = busy;
      cnt_nxt    = BUSY_W'(min1(32'(len)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the reset is
  // synchronous, so reset_n is only tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status <= ready;
      cnt    <= '0;
    end else begin
      status <= status_nxt;
      cnt    <= cnt_nxt;
    end
  end

  assign free     = (status == ready);
  assign busy_nxt = (status_nxt == busy);

endmodule

// File: rtl/short_multi.sv
// NCH-channel admission tracker: round-robin arbiter granting one ready,
// requesting channel per cycle, plus per-channel occupancy and a busy count.
module short_multi
  import short_pkg::*;
#(
  parameter int NCH    = NCH_DEF,
  parameter int BUSY_W = BUSY_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NCH-1:0]           request,
  input  logic [NCH-1:0]           early_release,
  input  logic [BUSY_W-1:0]        busy_len,
  output logic [NCH-1:0]           grant,
  output logic [NCH-1:0]           busy,
  output logic [$clog2(NCH+1)-1:0] nbusy,
  output logic                     all_busy
);

  localparam int PTR_W = $clog2(NCH);
  localparam int CNT_W = $clog2(NCH+1);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [NCH-1:0]   free;
  logic [NCH-1:0]   take;
  logic [NCH-1:0]   busy_nxt;
  logic [CNT_W-1:0] nbusy_nxt;
  logic             found;
  int               idx;
  status_e          status [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    short_chan #(.BUSY_W(BUSY_W)) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .take         (take[i]),
      .len          (busy_len),
      .early_release(early_release[i]),
      .status       (status[i]),
      .free         (free[i]),
      .busy_nxt     (busy_nxt[i])
    );
    assign busy[i] = (status[i] == short_pkg::busy);
  end

  // Round-robin search from ptr; a channel leaving busy this edge is not
  // yet free, so it cannot win until the next edge.
  always_comb begin
    take    = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr) + k) % NCH;
      if (!found && free[idx] && request[idx]) begin
        found     = 1'b1;
        take[idx] = 1'b1;
        ptr_nxt   = PTR_W'((idx + 1) % NCH);
      end
    end
  end

  always_comb begin
    nbusy_nxt = '0;
    for (int i = 0; i < NCH; i++) nbusy_nxt = nbusy_nxt + CNT_W'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr      <= '0;
      grant    <= '0;
      nbusy    <= '0;
      all_busy <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      grant    <= take;
      nbusy    <= nbusy_nxt;
      all_busy <= &busy_nxt;
    end
  end

endmodule

// File: tb/tb_short_multi.sv
// Self-checking bench for short_multi: remaining-cycles reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_short_multi;

  localparam int NCH    = 4;
  localparam int BUSY_W = 3;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NCH-1:0]    request;
  logic [NCH-1:0]    early_release;
  logic [BUSY_W-1:0] busy_len;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    busy;
  logic [CNT_W-1:0]  nbusy;
  logic              all_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  short_multi #(.NCH(NCH), .BUSY_W(BUSY_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .request      (request),
    .early_release(early_release),
    .busy_len     (busy_len),
    .grant        (grant),
    .busy         (busy),
    .nbusy        (nbusy),
    .all_busy     (all_busy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: each channel holds the number of busy cycles still owed.
  int             rem [NCH];
  int             mptr;
  int             w;
  logic [NCH-1:0] mgrant;
  bit             started = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) rem[i] = 0;
      mptr    = 0;
      mgrant  = '0;
      started = 1'b1;
    end else begin
      w = -1;
      for (int k = 0; k < NCH; k++)
        if (w < 0 && rem[(mptr + k) % NCH] == 0 && request[(mptr + k) % NCH]) w = (mptr + k) % NCH;
      for (int i = 0; i < NCH; i++)
        if (rem[i] > 0) rem[i] = (early_release[i] || rem[i] == 1) ? 0 : rem[i] - 1;
      mgrant = '0;
      if (w >= 0) begin
        rem[w]    = (busy_len == 0) ? 1 : int'(busy_len);
        mgrant[w] = 1'b1;
        mptr      = (w + 1) % NCH;
      end
    end
  end

  function automatic logic [NCH-1:0] model_busy();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = (rem[i] > 0);
    return v;
  endfunction

  function automatic int model_nbusy();
    int n = 0;
    for (int i = 0; i < NCH; i++) n += (rem[i] > 0) ? 1 : 0;
    return n;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("busy", 32'(busy), 32'(model_busy()));
      check("grant", 32'(grant), 32'(mgrant));
      check("nbusy", 32'(nbusy), 32'(model_nbusy()));
      check("all_busy", 32'(all_busy), 32'(model_nbusy() == NCH));
      check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    end
  end

  task automatic step(input logic r, input logic [NCH-1:0] q, input logic [NCH-1:0] rl,
                      input logic [BUSY_W-1:0] bl);
    @(negedge clk);
    reset_n       = r;
    request       = q;
    early_release = rl;
    busy_len      = bl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    request       = '0;
    early_release = '0;
    busy_len      = '0;

    // Requests during reset must never be admitted.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 4'b0000, 3'd7);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_nbusy", 32'(nbusy), 32'h0);
    end

    // Single request, length 3: busy for exactly 3 cycles, re-grant on the 4th edge.
    step(1'b1, 4'b0001, 4'b0000, 3'd3);
    check("single_grant", 32'(grant), 32'h1);
    check("single_busy0", 32'(busy), 32'h1);
    step(1'b1, 4'b0001, 4'b0000, 3'd3);
    check("single_grant_pulse", 32'(grant), 32'h0);
    check("single_busy1", 32'(busy), 32'h1);
    step(1'b1, 4'b0001, 4'b0000, 3'd3);
    check("single_busy2", 32'(busy), 32'h1);
    step(1'b1, 4'b0001, 4'b0000, 3'd3);
    check("single_ready", 32'(busy), 32'h0);
    check("single_no_early", 32'(grant), 32'h0);
    step(1'b1, 4'b0001, 4'b0000, 3'd3);
    check("single_regrant", 32'(grant), 32'h1);

    // Round-robin with all channels requesting.
    step(1'b0, 4'b0000, 4'b0000, 3'd0);
    for (int i = 0; i < NCH; i++) begin
      step(1'b1, 4'b1111, 4'b0000, 3'd7);
      check("rr_grant", 32'(grant), 32'(1 << i));
    end
    check("rr_all_busy", 32'(all_busy), 32'h1);
    check("rr_nbusy", 32'(nbusy), 32'd4);

    // Wrap fairness: after ptr reaches 2, channel 0 wins ahead of channel 1.
    step(1'b0, 4'b0000, 4'b0000, 3'd0);
    step(1'b1, 4'b0011, 4'b0000, 3'd1);
    check("wrap_g0", 32'(grant), 32'h1);
    step(1'b1, 4'b0011, 4'b0000, 3'd1);
    check("wrap_g1", 32'(grant), 32'h2);
    step(1'b1, 4'b0011, 4'b0000, 3'd1);
    check("wrap_g2", 32'(grant), 32'h1);
    step(1'b1, 4'b0011, 4'b0000, 3'd1);
    check("wrap_g3", 32'(grant), 32'h2);

    // Release coinciding with expiry, release on ready channels, mid-busy release.
    step(1'b0, 4'b0000, 4'b0000, 3'd0);
    step(1'b1, 4'b0010, 4'b0000, 3'd1);
    check("rel_grant", 32'(grant), 32'h2);
    step(1'b1, 4'b0000, 4'b0110, 3'd0);
    check("rel_expire_same", 32'(busy), 32'h0);
    step(1'b1, 4'b0000, 4'b1111, 3'd0);
    check("rel_on_ready", 32'(busy), 32'h0);
    check("rel_on_ready_nbusy", 32'(nbusy), 32'h0);
    step(1'b1, 4'b0010, 4'b0000, 3'd5);
    check("rel_grant5", 32'(grant), 32'h2);
    step(1'b1, 4'b0000, 4'b0000, 3'd0);
    check("rel_hold", 32'(busy), 32'h2);
    step(1'b1, 4'b0000, 4'b0010, 3'd0);
    check("rel_early", 32'(busy), 32'h0);

    // Zero length maps to one cycle; reset drops busy channels mid-operation.
    step(1'b0, 4'b0000, 4'b0000, 3'd0);
    step(1'b1, 4'b0001, 4'b0000, 3'd0);
    check("zero_busy", 32'(busy), 32'h1);
    step(1'b1, 4'b0000, 4'b0000, 3'd0);
    check("zero_done", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0111, 4'b0000, 3'd7);
    check("mid_nbusy", 32'(nbusy), 32'd3);
    check("mid_busy", 32'(busy), 32'h7);
    step(1'b0, 4'b1111, 4'b0000, 3'd7);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_grant", 32'(grant), 32'h0);
    step(1'b1, 4'b1111, 4'b0000, 3'd7);
    check("mid_rst_ptr", 32'(grant), 32'h1);

    // Randomized traffic with sparse releases and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 99) != 0), 4'($urandom),
           4'($urandom & $urandom & $urandom), 3'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
